// File: rtl/jvs_node_info_pkg.sv
// Shared types and constants for the JVS node information sequencer.
// The record layout is consumed directly by the debugger register block.
package jvs_node_info_pkg;

  localparam int MAX_JVS_NODES = 2;

  localparam logic [7:0] JVS_CMD_CMDREV    = 8'h11;
  localparam logic [7:0] JVS_CMD_JVSREV    = 8'h12;
  localparam logic [7:0] JVS_CMD_COMMVER   = 8'h13;
  localparam logic [7:0] JVS_STATUS_NORMAL = 8'h01;
  localparam logic [7:0] JVS_REPORT_NORMAL = 8'h01;

  typedef struct packed {
    logic [MAX_JVS_NODES-1:0][7:0] node_id;
    logic [MAX_JVS_NODES-1:0][7:0] node_cmd_ver;
    logic [MAX_JVS_NODES-1:0][7:0] node_jvs_ver;
    logic [MAX_JVS_NODES-1:0][7:0] node_com_ver;
  } jvs_node_info_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  function automatic logic [7:0] next_cmd(input logic [7:0] cmd);
    logic [7:0] nxt;
    case (cmd)
      JVS_CMD_CMDREV: nxt = JVS_CMD_JVSREV;
      JVS_CMD_JVSREV: nxt = JVS_CMD_COMMVER;
      default:        nxt = JVS_CMD_CMDREV;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jvs_node_info_sequencer_timeout.sv
// Response timeout counter: cleared on each command handshake, counts while
// waiting, saturates at all ones and flags expiry on the last allowed cycle.
module jvs_rsp_timeout #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WIDTH-1:0] count_r;

  // Saturating wait-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1);
    end
  end

  assign expire = enable && (count_r == LAST);

endmodule

// File: rtl/jvs_node_info_sequencer.sv
// Walks every addressed JVS node, issuing CMDREV/JVSREV/COMMVER with retry on
// bad or missing replies, and fills the node information record.
module jvs_node_info_sequencer
  import jvs_node_info_pkg::*;
#(
  parameter int          MAX_NODES   = MAX_JVS_NODES,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [7:0]     i_node_count,
  output logic           o_cmd_valid,
  input  logic           i_cmd_ready,
  output logic [7:0]     o_cmd_addr,
  output logic [7:0]     o_cmd_code,
  input  logic           i_rsp_valid,
  input  logic [7:0]     i_rsp_status,
  input  logic [7:0]     i_rsp_report,
  input  logic [7:0]     i_rsp_data,
  output jvs_node_info_t o_node_info,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error,
  output logic [7:0]     o_fail_node
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int NW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 24'd1);
  localparam logic [RW-1:0] MAX_RETRY_R = RW'(MAX_RETRY);
  localparam logic [7:0]    MAX_NODES_B = 8'(MAX_NODES);

  seq_state_t     state_r, state_next;
  logic [NW-1:0]  node_r, last_r;
  logic [7:0]     cmd_r, data_r, fail_node_r;
  logic [RW-1:0]  retry_r;
  logic           ok_r, error_r, cmd_valid_r, busy_r, done_r;
  jvs_node_info_t info_r;

  logic [7:0]     n_s;
  logic           start_s, hs_s, good_s, retry_s, fail_s, expire_s;

  jvs_rsp_timeout #(.WIDTH(TW), .LAST(TMO_LAST)) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (hs_s),
    .enable (state_r == ST_WAIT),
    .expire (expire_s)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_next;
  end

  // Next-state decode; a response arriving on the expiry cycle takes priority
  always_comb begin
    state_next = state_r;
    start_s    = 1'b0;
    hs_s       = 1'b0;
    good_s     = 1'b0;
    retry_s    = 1'b0;
    fail_s     = 1'b0;
    n_s        = (i_node_count > MAX_NODES_B) ? MAX_NODES_B : i_node_count;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          start_s    = 1'b1;
          state_next = (n_s == 8'd0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_next = state_r;
        end
      end
      ST_ISSUE: begin
        if (cmd_valid_r && i_cmd_ready) begin
          hs_s       = 1'b1;
          state_next = ST_WAIT;
        end else begin
          state_next = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (i_rsp_valid && (i_rsp_status == JVS_STATUS_NORMAL) &&
            (i_rsp_report == JVS_REPORT_NORMAL)) begin
          good_s     = 1'b1;
          state_next = ST_STORE;
        end else if (i_rsp_valid || expire_s) begin
          if (retry_r < MAX_RETRY_R) begin
            retry_s    = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            fail_s     = 1'b1;
            state_next = ST_STORE;
          end
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_STORE: begin
        if ((node_r == last_r) && (cmd_r == JVS_CMD_COMMVER)) state_next = ST_DONE;
        else                                                  state_next = ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: record, progress counters and registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      node_r      <= '0;
      last_r      <= '0;
      cmd_r       <= 8'h00;
      data_r      <= 8'h00;
      retry_r     <= '0;
      ok_r        <= 1'b0;
      error_r     <= 1'b0;
      fail_node_r <= 8'h00;
      info_r      <= '0;
      cmd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cmd_valid_r <= (state_next == ST_ISSUE);
      busy_r      <= (state_next == ST_ISSUE) || (state_next == ST_WAIT) ||
                     (state_next == ST_STORE);
      done_r      <= (state_next == ST_DONE);
      if (start_s) begin
        info_r      <= '0;
        error_r     <= 1'b0;
        fail_node_r <= 8'h00;
        last_r      <= NW'(n_s - 8'd1);
        node_r      <= '0;
        cmd_r       <= JVS_CMD_CMDREV;
        retry_r     <= '0;
        if (n_s != 8'd0) info_r.node_id[0] <= 8'h01;
      end else if (state_r == ST_WAIT) begin
        if (good_s) begin
          data_r <= i_rsp_data;
          ok_r   <= 1'b1;
        end else if (fail_s) begin
          ok_r   <= 1'b0;
        end else if (retry_s) begin
          retry_r <= retry_r + RW'(1);
        end
      end else if (state_r == ST_STORE) begin
        retry_r <= '0;
        if (ok_r) begin
          case (cmd_r)
            JVS_CMD_CMDREV:  info_r.node_cmd_ver[node_r] <= data_r;
            JVS_CMD_JVSREV:  info_r.node_jvs_ver[node_r] <= data_r;
            JVS_CMD_COMMVER: info_r.node_com_ver[node_r] <= data_r;
            default:         ;
          endcase
        end else begin
          error_r <= 1'b1;
          if (fail_node_r == 8'h00) fail_node_r <= 8'(node_r) + 8'd1;
        end
        if (cmd_r == JVS_CMD_COMMVER) begin
          cmd_r <= JVS_CMD_CMDREV;
          if (state_next != ST_DONE) begin
            node_r                       <= node_r + NW'(1);
            info_r.node_id[node_r + NW'(1)] <= 8'(node_r) + 8'd2;
          end
        end else begin
          cmd_r <= next_cmd(cmd_r);
        end
      end
    end
  end

  assign o_cmd_valid = cmd_valid_r;
  assign o_cmd_addr  = 8'(node_r) + 8'd1;
  assign o_cmd_code  = cmd_r;
  assign o_node_info = info_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_error     = error_r;
  assign o_fail_node = fail_node_r;

endmodule

// File: tb/tb_jvs_node_info_sequencer.sv
// Bench for the node info sequencer: a reactive frame-engine responder plus a
// per-command outcome model predicting issue order, record and error status.
module tb_jvs_node_info_sequencer;
  import jvs_node_info_pkg::*;

  localparam logic [23:0] TMO     = 24'd100;
  localparam int          RETRIES = 2;

  logic           clk = 1'b0;
  logic           rst_n, start, ready, rsp_valid;
  logic [7:0]     node_count, status, report, data;
  logic           cmd_valid, busy, done, error;
  logic [7:0]     cmd_addr, cmd_code, fail_node;
  jvs_node_info_t info;

  always #5 clk = ~clk;

  jvs_node_info_sequencer #(.MAX_NODES(2), .TIMEOUT_CYC(TMO), .MAX_RETRY(RETRIES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_node_count(node_count),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(ready), .o_cmd_addr(cmd_addr), .o_cmd_code(cmd_code),
    .i_rsp_valid(rsp_valid), .i_rsp_status(status), .i_rsp_report(report), .i_rsp_data(data),
    .o_node_info(info), .o_busy(busy), .o_done(done), .o_error(error), .o_fail_node(fail_node)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // behaviour per attempt: 0 good, 1 bad report, 2 bad status, 3 no answer
  int         beh [2][3][3];
  int         dly [2][3][3];
  logic [7:0] dat [2][3];
  int         att [2][3];
  int         ready_mode = 0;
  int         cycle = 0;
  logic       hs_r = 1'b0;
  logic [15:0] hs_word_r = 16'h0000;
  logic [15:0] got_q[$];
  int          got_cyc[$];
  logic [15:0] exp_q[$];
  jvs_node_info_t exp_info;
  logic        exp_err;
  logic [7:0]  exp_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cycle     <= cycle + 1;
    hs_r      <= rst_n && cmd_valid && ready;
    hs_word_r <= {cmd_addr, cmd_code};
  end

  initial begin : responder
    int  k, c, a, b, cd;
    bit  pend;
    logic [7:0] p_status, p_report, p_data;
    pend = 1'b0; cd = 0;
    p_status = 8'h00; p_report = 8'h00; p_data = 8'h00;
    ready = 1'b1; rsp_valid = 1'b0; status = 8'h00; report = 8'h00; data = 8'h00;
    forever begin
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (hs_r) begin
        got_q.push_back(hs_word_r);
        got_cyc.push_back(cycle);
        k = int'(hs_word_r[15:8]) - 1;
        c = int'(hs_word_r[7:0]) - 17;
        if (k >= 0 && k < 2 && c >= 0 && c < 3) begin
          a = att[k][c];
          att[k][c]++;
          if (a > 2) a = 2;
          b = beh[k][c][a];
          if (b != 3) begin
            pend     = 1'b1;
            cd       = dly[k][c][a];
            p_status = (b == 2) ? 8'h04 : 8'h01;
            p_report = (b == 1) ? 8'h02 : 8'h01;
            p_data   = (b == 0) ? dat[k][c] : 8'hEE;
          end
        end
      end
      if (pend && rst_n) begin
        if (cd == 0) begin
          rsp_valid = 1'b1; status = p_status; report = p_report; data = p_data;
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
      if (ready_mode == 1)      ready = ($urandom_range(0, 3) != 0);
      else if (ready_mode == 2) ready = 1'b0;
      else                      ready = 1'b1;
    end
  end

  task automatic set_all_good();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) begin
        dat[k][c] = 8'h10 + 8'(k * 3 + c);
        for (int a = 0; a < 3; a++) begin beh[k][c][a] = 0; dly[k][c][a] = 0; end
      end
  endtask

  // Outcome of each command = first good attempt within 1+RETRIES tries
  task automatic compute_expected(input int count);
    int n, g, tries;
    n = (count < 2) ? count : 2;
    exp_q.delete();
    exp_info = '0; exp_err = 1'b0; exp_fail = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_info.node_id[k] = 8'(k + 1);
      for (int c = 0; c < 3; c++) begin
        g = -1;
        for (int a = 0; a <= RETRIES; a++) if (g < 0 && beh[k][c][a] == 0) g = a;
        tries = (g < 0) ? RETRIES + 1 : g + 1;
        for (int a = 0; a < tries; a++) exp_q.push_back({8'(k + 1), 8'(17 + c)});
        if (g < 0) begin
          exp_err = 1'b1;
          if (exp_fail == 8'h00) exp_fail = 8'(k + 1);
        end else if (c == 0) exp_info.node_cmd_ver[k] = dat[k][c];
        else if (c == 1)     exp_info.node_jvs_ver[k] = dat[k][c];
        else                 exp_info.node_com_ver[k] = dat[k][c];
      end
    end
  endtask

  task automatic run_pass(input int count, input bit dbl_start, input bit hold_low);
    int waited;
    compute_expected(count);
    for (int k = 0; k < 2; k++) for (int c = 0; c < 3; c++) att[k][c] = 0;
    got_q.delete(); got_cyc.delete();
    if (hold_low) ready_mode = 2;
    node_count = 8'(count); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_done", done, (count == 0) ? 1'b1 : 1'b0);
    check_eq("start_busy", busy, (count == 0) ? 1'b0 : 1'b1);
    if (hold_low) begin
      for (int i = 0; i < 20; i++) begin
        check_eq("hold_stable", {cmd_valid, cmd_addr, cmd_code}, {1'b1, 8'h01, 8'h11});
        @(posedge clk); #1;
      end
      ready_mode = 0;
    end
    if (dbl_start) begin
      repeat (3) @(posedge clk);
      #1; node_count = 8'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("start_while_busy", {busy, done}, {1'b1, 1'b0});
    end
    waited = 0;
    while (!done && waited < 6000) begin @(posedge clk); #1; waited++; end
    check_eq("done_in_time", done, 1'b1);
    check_eq("idle_outputs", {busy, cmd_valid}, {1'b0, 1'b0});
    check_eq("error", error, exp_err);
    check_eq("fail_node", fail_node, exp_fail);
    for (int k = 0; k < 2; k++) begin
      check_eq("node_id", info.node_id[k], exp_info.node_id[k]);
      check_eq("cmd_ver", info.node_cmd_ver[k], exp_info.node_cmd_ver[k]);
      check_eq("jvs_ver", info.node_jvs_ver[k], exp_info.node_jvs_ver[k]);
      check_eq("com_ver", info.node_com_ver[k], exp_info.node_com_ver[k]);
    end
    check_eq("issue_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq("issue_seq", got_q[i], exp_q[i]);
  endtask

  initial begin : main
    int waited, r;
    rst_n = 1'b0; start = 1'b0; node_count = 8'd0;
    set_all_good();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {cmd_valid, busy, done, error, fail_node}, 12'h000);
    check_eq("rst_info", info, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // nominal two-node pass
    set_all_good();
    dat[0][0] = 8'h13; dat[0][1] = 8'h30; dat[0][2] = 8'h10;
    dat[1][0] = 8'h12; dat[1][1] = 8'h20; dat[1][2] = 8'h10;
    run_pass(2, 1'b0, 1'b0);

    // engine stalls for 20 cycles on the first command
    run_pass(2, 1'b0, 1'b1);

    // node 2 JVSREV never answers: three issues one timeout apart
    set_all_good();
    for (int a = 0; a < 3; a++) beh[1][1][a] = 3;
    run_pass(2, 1'b0, 1'b0);
    if (got_cyc.size() >= 7) begin
      check_eq("tmo_gap1", got_cyc[5] - got_cyc[4], 32'(TMO) + 1);
      check_eq("tmo_gap2", got_cyc[6] - got_cyc[5], 32'(TMO) + 1);
    end else begin
      check_eq("tmo_issue_count", got_cyc.size(), 7);
    end

    // bad report then good retry
    set_all_good();
    beh[0][0][0] = 1; dly[0][0][0] = 4; dat[0][0] = 8'h13;
    run_pass(2, 1'b0, 1'b0);

    // empty and over-range node counts
    set_all_good();
    run_pass(0, 1'b0, 1'b0);
    run_pass(5, 1'b0, 1'b0);

    // reset while node 2 waits, with an error already latched
    set_all_good();
    for (int a = 0; a < 3; a++) beh[0][2][a] = 3;
    dly[1][0][0] = 10;
    for (int k = 0; k < 2; k++) for (int c = 0; c < 3; c++) att[k][c] = 0;
    got_q.delete(); got_cyc.delete();
    node_count = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (got_q.size() < 6 && waited < 2000) begin @(posedge clk); #1; waited++; end
    check_eq("reached_node2", got_q.size(), 6);
    check_eq("pre_rst_error", error, 1'b1);
    #2; rst_n = 1'b0;
    #1;
    check_eq("async_rst_outputs", {cmd_valid, busy, done, error, fail_node}, 12'h000);
    check_eq("async_rst_info", info, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_all_good();
    run_pass(2, 1'b1, 1'b0);

    // randomized passes
    for (int p = 0; p < 15; p++) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 3; c++) begin
          dat[k][c] = 8'($urandom_range(0, 255));
          for (int a = 0; a < 3; a++) begin
            r = $urandom_range(0, 9);
            beh[k][c][a] = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 0 : 3;
            dly[k][c][a] = $urandom_range(0, 20);
          end
        end
      ready_mode = $urandom_range(0, 1);
      @(posedge clk); #1;
      run_pass($urandom_range(0, 4), 1'b0, 1'b0);
      ready_mode = 0;
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/jvs_node_info_sequencer.md
Name: jvs_node_info_sequencer

Overview:
- Post-enumeration controller that gathers version information from every addressed JVS node and fills a jvs_node_info_t record.
- For each node in turn it issues CMDREV (0x11), JVSREV (0x12) and COMMVER (0x13) to the JVS frame engine over a request/response handshake, validates each reply and stores its data byte.
- Sits between the JVS address-assignment logic, which provides the node count, and the debugger display/register block, which consumes the filled record.

Parameters:
- MAX_NODES, jvs_node_info_pkg::MAX_JVS_NODES (2), number of record slots.
- TIMEOUT_CYC, 24'd5_000_000, clock cycles to wait for a response before a retry.
- MAX_RETRY, 2, retries per command after the first attempt.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; begin a collection pass (ignored unless IDLE or DONE).
- i_node_count  in  8  number of addressed nodes; sampled on i_start.
- o_cmd_valid  out  1  command request valid.
- i_cmd_ready  in  1  frame engine accepts the command when o_cmd_valid & i_cmd_ready.
- o_cmd_addr  out  8  target node address (slot index + 1).
- o_cmd_code  out  8  JVS command byte.
- i_rsp_valid  in  1  single-cycle pulse; response available.
- i_rsp_status  in  8  frame status byte (0x01 = normal).
- i_rsp_report  in  8  per-command report byte (0x01 = normal).
- i_rsp_data  in  8  first payload byte (BCD version).
- o_node_info  out  jvs_node_info_t  collected record.
- o_busy  out  1  pass in progress.
- o_done  out  1  level; pass finished, held until the next i_start.
- o_error  out  1  level; at least one command failed during the last pass.
- o_fail_node  out  8  address of the first failing node, 0 if none.

Behaviour:
- Reset: state IDLE; every o_node_info field 8'h00; o_cmd_valid, o_busy, o_done, o_error 0; o_fail_node 0; all counters 0.
- States: IDLE -> ISSUE -> WAIT -> STORE -> (ISSUE | DONE). ERROR_SKIP is folded into STORE.
- i_start in IDLE or DONE:
  - Clear o_done, o_error, o_fail_node and all record fields.
  - Latch n = min(i_node_count, MAX_NODES).
  - If n == 0, go straight to DONE: o_done is 1 in the next cycle.
  - Otherwise node = 0, cmd = CMDREV, node_id[0] = 8'h01, go to ISSUE.
- ISSUE:
  - o_cmd_valid = 1, with o_cmd_addr and o_cmd_code stable while valid.
  - On the handshake cycle, drop valid in the next cycle, clear the timeout counter and go to WAIT.
  - Valid must not drop before ready.
- WAIT:
  - The timeout counter increments each cycle.
  - i_rsp_valid with status == 0x01 and report == 0x01: register i_rsp_data and go to STORE.
  - i_rsp_valid with a bad status/report, or counter == TIMEOUT_CYC - 1: if retries < MAX_RETRY, increment retries and return to ISSUE. Otherwise mark the command failed and go to STORE.
  - If i_rsp_valid and the timeout coincide, the response wins.
  - i_rsp_valid outside WAIT is ignored.
- STORE (1 cycle):
  - On success, write data to node_cmd_ver, node_jvs_ver or node_com_ver[node], selected by cmd.
  - On failure, leave the field at 0x00, set o_error, and set o_fail_node to node+1 if it is still 0.
  - Reset retries.
  - Next cmd in order CMDREV -> JVSREV -> COMMVER. After COMMVER, node++, write node_id[node] = node+1 and restart at CMDREV.
  - Go to DONE when node == n-1 and cmd == COMMVER.
  - A failed command does not abort the pass; the remaining commands and nodes continue.
- DONE: o_done = 1, o_busy = 0, record held stable.
- o_busy = 1 in ISSUE, WAIT and STORE.
- i_start while busy is ignored.
- Latency per command is 1 (issue) + handshake wait + response wait + 1 (store) cycles. Each field updates the cycle after STORE; the record is stable whenever o_done = 1.
- Width rules:
  - Timeout counter is $clog2(TIMEOUT_CYC) bits, saturating.
  - Retry counter is $clog2(MAX_RETRY+1) bits.
  - Node index is $clog2(MAX_NODES) bits, minimum 1.
- Asynchronous reset mid-pass returns everything to reset values immediately, including dropping o_cmd_valid.

Decomposition:
- Add to jvs_node_info_pkg:
  - Command constants JVS_CMD_CMDREV = 8'h11, JVS_CMD_JVSREV = 8'h12, JVS_CMD_COMMVER = 8'h13.
  - JVS_STATUS_NORMAL = 8'h01, JVS_REPORT_NORMAL = 8'h01.
  - State enum seq_state_t.
- One sub-module: jvs_rsp_timeout, a loadable saturating counter with clear/enable and expiry pulse. The rest stays in one FSM.

Test Plan:
1. n=2, engine always ready, responses 0x13, 0x30, 0x10 for node 1 and 0x12, 0x20, 0x10 for node 2, all status/report 0x01 -> six command handshakes in order 0x11, 0x12, 0x13 to addr 1 then addr 2; record node_id {01, 02}, cmd {13, 12}, jvs {30, 20}, com {10, 10}; o_done = 1; o_error = 0.
2. i_cmd_ready held low 20 cycles -> o_cmd_valid, addr and code stable all 20 cycles; exactly one handshake.
3. Node 2 JVSREV never answers, MAX_RETRY=2, TIMEOUT_CYC=100 -> three 0x12 issues to addr 2, about 100 cycles apart; node_jvs_ver[1] = 00; o_error = 1; o_fail_node = 02; COMMVER is still issued and stored.
4. First CMDREV reply has report 0x02, retry reply is normal with data 0x13 -> node_cmd_ver[0] = 13; o_error = 0.
5. i_node_count = 0, then separately i_node_count = 5 -> DONE one cycle after start with no commands; the count of 5 is clamped to 2 nodes.
6. Assert i_rst_n low during WAIT of node 2, then start again -> outputs clear asynchronously; the new pass completes normally; a second i_start while busy has no effect.
